pcm_to_i2s_tx: RTL
==================

// Module: pcm_to_i2s_tx
// PURPOSE
// - Stereo PCM-to-I2S transmitter: takes parallel left/right sample pairs and serialises
//   them as Philips I2S (sck, ws, sd), MSB first.
// - Transmit counterpart of the on-chip I2S receiver; drives beamformer output and loopback.
// - Generates its own sck/ws from clk (controller mode).
// PARAMETERS
// - NUMBER_OF_BITS  8  sample width per channel; shared constant; must be <= SLOT_BITS
// - SLOT_BITS       16 sck periods per channel slot; frame = 2*SLOT_BITS bits
// - CLK_DIV         2  clk cycles per sck half-period, >= 1
// PORTS
// - clk               in   1    system clock; all logic on posedge
// - rst_n             in   1    asynchronous active-low reset
// - in_valid          in   1    sample pair on in_left/in_right is valid
// - in_ready          out  1    holding register empty; transfer when in_valid & in_ready
// - in_left           in   NUMBER_OF_BITS  left sample, two's complement
// - in_right          in   NUMBER_OF_BITS  right sample, two's complement
// - sck               out  1    I2S bit clock, 50% duty
// - ws                out  1    word select: 0 = left, 1 = right
// - sd                out  1    serial data; changes on sck falling edge
// - underrun_cnt      out  8    underrun count (only with I2S_TX_UNDERRUN_CNT_EN)
// BEHAVIOUR
// - Reset (async): sck=0, ws=0, sd=0, in_ready=1, holding empty, frame reg 0,
//   pos=2*SLOT_BITS-1, underrun_cnt=0. No transfer is accepted while rst_n=0.
// - Divider: counter 0..CLK_DIV-1. On wrap, sck toggles.
//   Each 1->0 toggle produces one-cycle strobe fall_stb.
// - Frame position pos (0..2*SLOT_BITS-1) advances on fall_stb and wraps to 0.
//   sd, ws and pos update in the same clk cycle as fall_stb.
// - ws = 1 for pos in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0.
//   This gives the one-bit I2S lead: ws flips on the LSB of the preceding slot.
// - sd by position:
//   - Left slot, pos 0..SLOT_BITS-1: frame_left[NUMBER_OF_BITS-1-pos] for pos < NUMBER_OF_BITS, else 0.
//   - Right slot: the same rule at pos-SLOT_BITS, using frame_right.
// - Frame load: on the fall_stb where pos wraps to 0 (the frame reg drives the first bit at pos 0):
//   - Holding full: copy holding into the frame reg and clear full.
//   - Holding empty: underrun. Frame reg is loaded with zeros, so silence is sent.
// - in_ready = !full (registered, no combinational path from in_valid).
// - A transfer sets full in the next cycle. A load and a transfer never coincide, because
//   in_ready is 0 whenever a load can occur.
// - First frame after reset starts on the first fall_stb: 2*CLK_DIV clk cycles after rst_n rises.
// - Latency: sample accepted before a frame boundary appears as the left MSB on sd at that boundary.
//   Worst case is one full frame plus one bit.
// - Reset mid-frame: all outputs go immediately to their reset values, the holding sample is
//   discarded, and framing restarts at pos 0.
// - Simple FSM (state in shared package): ST_SYNC waits for the first fall_stb after reset;
//   ST_RUN runs continuously. Only reset returns the FSM to ST_SYNC.
// CONFIGURATION
// - I2S_TX_UNDERRUN_CNT_EN defined:
//   - underrun_cnt increments on every underrun load and saturates at 8'hFF.
//   - Cleared only by reset.
// - Not defined: the underrun_cnt port is absent and no counter logic is built.
// - Underrun silence is sent in both builds.
// CONSTANTS AND SUB-MODULES
// - Shared package: NUMBER_OF_BITS, the FSM state encoding (ST_SYNC, ST_RUN), and the
//   slot/position width helper $clog2(2*SLOT_BITS).
// - One sub-module, i2s_tx_clkgen: divider producing sck and fall_stb, reset to sck=0.
// TESTING (NUMBER_OF_BITS=8, SLOT_BITS=8, CLK_DIV=2 unless noted)
// - Push L=8'hA5, R=8'h3C before the first boundary:
//   sd over one frame = 1010_0101_0011_1100; ws=0 for pos 0..6 and 15, ws=1 for pos 7..14.
// - SLOT_BITS=16, L=8'h81:
//   left slot sd = 1000_0001 followed by 8 zeros; the right slot is all zeros.
// - Back-to-back pushes:
//   in_ready drops the cycle after the first transfer and rises the cycle after the frame load.
//   The second pair is held until the next boundary; no data is lost.
// - No pushes for 3 frames: sd stays 0 throughout.
//   With I2S_TX_UNDERRUN_CNT_EN, underrun_cnt = 3; after 300 frames it saturates at 255.
// - Assert rst_n=0 at pos 5 with the holding register full:
//   same cycle sck=ws=sd=0 and in_ready=1. After release, the first fall_stb comes after
//   4 clk cycles and the frame is silent.
// - Timing check: sck period = 4 clk cycles. sd and ws change only in the clk cycle of the
//   sck falling edge and are stable across every sck rising edge.

Source files
------------

// File: rtl/pcm_to_i2s_tx_pkg.sv
// Shared constants for the PCM-to-I2S transmitter: sample width, FSM encoding, position width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcm_to_i2s_tx_pkg;

    localparam int NUMBER_OF_BITS = 8;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    function automatic int pos_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// I2S bit-clock divider: sck toggles every CLK_DIV clk cycles, fall_stb flags each 1->0 toggle.
// Latency: fall_stb is high in the clk cycle whose closing edge drives sck low.
// Backpressure: none, free-running.
module i2s_tx_clkgen
    import pcm_to_i2s_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck,
    output logic fall_stb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] WRAP = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = (div_cnt == WRAP);
    assign fall_stb = wrap && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/pcm_to_i2s_tx.sv
// Stereo PCM to Philips I2S transmitter (controller mode); optional underrun counter via I2S_TX_UNDERRUN_CNT_EN.
// Latency: a pair accepted before a frame boundary is the left MSB at that boundary; worst case one frame plus one bit.
// Backpressure: in_ready low while the single holding register is full; empty holding at a boundary sends silence.
module pcm_to_i2s_tx
    import pcm_to_i2s_tx_pkg::*;
#(
    parameter int SLOT_BITS = 16,
    parameter int CLK_DIV   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                underrun_cnt
`endif
);

    localparam int PW = pos_width(SLOT_BITS);
    localparam int BW = (NUMBER_OF_BITS > 1) ? $clog2(NUMBER_OF_BITS) : 1;
    localparam logic [PW-1:0] SLOT_P = PW'(SLOT_BITS);
    localparam logic [PW-1:0] LAST_P = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_LO  = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_HI  = PW'(2 * SLOT_BITS - 2);
    localparam logic [PW-1:0] NB_P   = PW'(NUMBER_OF_BITS);
    localparam logic [BW-1:0] MSB_I  = BW'(NUMBER_OF_BITS - 1);

    logic                      fall_stb;
    tx_state_t                 state, state_nxt;
    logic [PW-1:0]             pos, pos_nxt, spos;
    logic                      full, take, boundary, right_slot;
    logic [NUMBER_OF_BITS-1:0] hold_l, hold_r, frame_l, frame_r;
    logic [NUMBER_OF_BITS-1:0] frame_l_nxt, frame_r_nxt, sel;
    logic [BW-1:0]             bit_idx;
    logic                      sd_nxt, ws_nxt;

    i2s_tx_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC: if (fall_stb) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_SYNC;
        else        state <= state_nxt;
    end

    assign in_ready = !full;
    assign take     = in_valid && !full;
    assign boundary = fall_stb && ((state == ST_SYNC) || (pos == LAST_P));

    // sd/ws are computed from the position being entered, so they land with the falling sck edge.
    always_comb begin
        pos_nxt     = boundary ? '0 : pos + PW'(1);
        frame_l_nxt = frame_l;
        frame_r_nxt = frame_r;
        if (boundary) begin
            frame_l_nxt = full ? hold_l : '0;
            frame_r_nxt = full ? hold_r : '0;
        end
        right_slot = (pos_nxt >= SLOT_P);
        spos       = right_slot ? (pos_nxt - SLOT_P) : pos_nxt;
        sel        = right_slot ? frame_r_nxt : frame_l_nxt;
        bit_idx    = MSB_I - BW'(spos);
        sd_nxt     = (spos < NB_P) && sel[bit_idx];
        ws_nxt     = (pos_nxt >= WS_LO) && (pos_nxt <= WS_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= LAST_P;
            sd      <= 1'b0;
            ws      <= 1'b0;
            frame_l <= '0;
            frame_r <= '0;
        end else if (fall_stb) begin
            pos     <= pos_nxt;
            sd      <= sd_nxt;
            ws      <= ws_nxt;
            frame_l <= frame_l_nxt;
            frame_r <= frame_r_nxt;
        end
    end

    // take needs !full and a load needs full, so the two branches are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (take) begin
            full   <= 1'b1;
            hold_l <= in_left;
            hold_r <= in_right;
        end else if (boundary && full) begin
            full   <= 1'b0;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= 8'h00;
        else if (boundary && !full && (underrun_cnt != 8'hFF))
            underrun_cnt <= underrun_cnt + 8'h01;
    end
`endif

endmodule
